// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter: one WIDTH-bit word becomes WIDTH serial bits.
// Each serial bit is held for DIV clocks, and words can be sent back to back with no gap.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int BIT_W  = $clog2(WIDTH + 1);
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(WIDTH - 1);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(DIV - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                sout_q, sout_d;
  logic                sout_valid_q, sout_valid_d;
  logic                sout_last_q, sout_last_d;
  logic                busy_q, busy_d;
  logic                last_cycle_s;
  logic                accept_s;

  // The bit on the wire always sits at the outgoing end of the shift register.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Handshake: rst_n gates in_ready so it reads 0 throughout reset.
  always_comb begin
    last_cycle_s = (state_q == SHIFT) && (tick_q == TICK_MAX) && (bit_cnt_q == BIT_MAX);
    in_ready     = rst_n & ~clear & ((state_q == IDLE) | last_cycle_s);
    accept_s     = in_valid & in_ready;
  end

  // Next-state, counter and shift-register logic.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    if (clear) begin
      state_d   = IDLE;
      shreg_d   = {WIDTH{1'b0}};
      tick_d    = {TICK_W{1'b0}};
      bit_cnt_d = {BIT_W{1'b0}};
    end else if (accept_s) begin
      state_d   = SHIFT;
      shreg_d   = in_data;
      tick_d    = {TICK_W{1'b0}};
      bit_cnt_d = {BIT_W{1'b0}};
    end else begin
      case (state_q)
        SHIFT: begin
          if (tick_q == TICK_MAX) begin
            tick_d = {TICK_W{1'b0}};
            if (bit_cnt_q == BIT_MAX) begin
              state_d   = IDLE;
              shreg_d   = {WIDTH{1'b0}};
              bit_cnt_d = {BIT_W{1'b0}};
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
              shreg_d   = shift_word(shreg_q);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        IDLE: begin
          state_d = IDLE;
        end
        default: begin
          state_d   = IDLE;
          shreg_d   = {WIDTH{1'b0}};
          tick_d    = {TICK_W{1'b0}};
          bit_cnt_d = {BIT_W{1'b0}};
        end
      endcase
    end
  end

  // Serial outputs are registered from the next state, so the first bit appears one clock after acceptance.
  always_comb begin
    busy_d       = (state_d == SHIFT);
    sout_valid_d = busy_d;
    sout_d       = busy_d & out_bit(shreg_d);
    sout_last_d  = busy_d & (bit_cnt_d == BIT_MAX);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= {WIDTH{1'b0}};
      tick_q       <= {TICK_W{1'b0}};
      bit_cnt_q    <= {BIT_W{1'b0}};
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      tick_q       <= tick_d;
      bit_cnt_q    <= bit_cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_last_q  <= sout_last_d;
      busy_q       <= busy_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sout_last  = sout_last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer.
// dut0 uses WIDTH=8, DIV=1, MSB first; dut1 uses WIDTH=8, DIV=3, LSB first.
module tb_piso_serializer;

  logic       clk;
  logic       rst_n;
  logic       clear0, in_valid0;
  logic [7:0] in_data0;
  logic       ready0, sout0, sv0, sl0, busy0;
  logic       clear1, in_valid1;
  logic [7:0] in_data1;
  logic       ready1, sout1, sv1, sl1, busy1;

  int n_vec;
  int n_err;

  piso_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear0), .in_valid(in_valid0), .in_data(in_data0),
    .in_ready(ready0), .sout(sout0), .sout_valid(sv0), .sout_last(sl0), .busy(busy0)
  );

  piso_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(ready1), .sout(sout1), .sout_valid(sv1), .sout_last(sl1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle0(input string tag);
    chk({tag, ".sout"}, sout0, 1'b0);
    chk({tag, ".valid"}, sv0, 1'b0);
    chk({tag, ".last"}, sl0, 1'b0);
    chk({tag, ".busy"}, busy0, 1'b0);
    chk({tag, ".ready"}, ready0, 1'b1);
  endtask

  // Runs n serial cycles on dut0 (DIV=1) after an accept on the next edge.
  task automatic stream0(input string tag, input logic [15:0] bits, input int n,
                         input int drop_at, input bit junk, input logic [7:0] next_word);
    for (int k = 1; k <= n; k++) begin
      tick();
      chk($sformatf("%s.sout%0d", tag, k), sout0, bits[n-k]);
      chk($sformatf("%s.valid%0d", tag, k), sv0, 1'b1);
      chk($sformatf("%s.last%0d", tag, k), sl0, (k % 8) == 0);
      chk($sformatf("%s.ready%0d", tag, k), ready0, (k % 8) == 0);
      chk($sformatf("%s.busy%0d", tag, k), busy0, 1'b1);
      if (k == drop_at) in_valid0 = 1'b0;
      if (junk && k < 7) in_data0 = 8'(k * 17);
      else if (k == 7) in_data0 = next_word;
    end
    tick();
    idle0({tag, ".end"});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear0 = 1'b0; in_valid0 = 1'b0; in_data0 = 8'h00;
    clear1 = 1'b0; in_valid1 = 1'b0; in_data1 = 8'h00;

    #2;
    chk("rst.ready0", ready0, 1'b0);
    chk("rst.sv0", sv0, 1'b0);
    chk("rst.busy0", busy0, 1'b0);
    chk("rst.ready1", ready1, 1'b0);
    chk("rst.sv1", sv1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    idle0("post_rst");
    chk("post_rst.ready1", ready1, 1'b1);

    // Single word 0xA5, MSB first.
    in_valid0 = 1'b1; in_data0 = 8'hA5;
    stream0("a5", 16'h00A5, 8, 1, 1'b0, 8'hA5);

    // Back-to-back 0xA5, 0x3C with in_valid held.
    in_valid0 = 1'b1; in_data0 = 8'hA5;
    stream0("b2b", 16'hA53C, 16, 9, 1'b0, 8'h3C);

    // DIV=3, LSB first: 0x01 gives three 1s then twenty-one 0s.
    in_valid1 = 1'b1; in_data1 = 8'h01;
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk($sformatf("div3.sout%0d", k), sout1, k <= 3);
      chk($sformatf("div3.valid%0d", k), sv1, 1'b1);
      chk($sformatf("div3.last%0d", k), sl1, k >= 22);
      chk($sformatf("div3.ready%0d", k), ready1, k == 24);
      chk($sformatf("div3.busy%0d", k), busy1, 1'b1);
      if (k == 1) in_valid1 = 1'b0;
    end
    tick();
    chk("div3.end.valid", sv1, 1'b0);
    chk("div3.end.last", sl1, 1'b0);
    chk("div3.end.busy", busy1, 1'b0);
    chk("div3.end.ready", ready1, 1'b1);

    // Clear during bit 4 of 0xFF, with in_valid high on the clear edge.
    in_valid0 = 1'b1; in_data0 = 8'hFF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("clr.sout%0d", k), sout0, 1'b1);
      chk($sformatf("clr.busy%0d", k), busy0, 1'b1);
      if (k == 1) in_valid0 = 1'b0;
    end
    clear0 = 1'b1; in_valid0 = 1'b1; in_data0 = 8'h80;
    #1;
    chk("clr.ready_during", ready0, 1'b0);
    tick();
    chk("clr.after.valid", sv0, 1'b0);
    chk("clr.after.busy", busy0, 1'b0);
    chk("clr.after.sout", sout0, 1'b0);
    chk("clr.after.last", sl0, 1'b0);
    clear0 = 1'b0;
    #1;
    chk("clr.after.ready", ready0, 1'b1);
    stream0("clr80", 16'h0080, 8, 1, 1'b0, 8'h80);

    // Asynchronous reset in the middle of a word.
    in_valid0 = 1'b1; in_data0 = 8'hA5;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1) in_valid0 = 1'b0;
    end
    chk("arst.pre.busy", busy0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.sout", sout0, 1'b0);
    chk("arst.valid", sv0, 1'b0);
    chk("arst.last", sl0, 1'b0);
    chk("arst.busy", busy0, 1'b0);
    chk("arst.ready", ready0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    idle0("arst.rel");
    in_valid0 = 1'b1; in_data0 = 8'h5A;
    stream0("arst5a", 16'h005A, 8, 1, 1'b0, 8'h5A);

    // in_data churns while busy; only the in_ready-cycle value is taken.
    in_valid0 = 1'b1; in_data0 = 8'hC3;
    stream0("hold", 16'hC396, 16, 9, 1'b1, 8'h96);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
